// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
// One request may be outstanding; imem_data is valid in the cycle imem_rdy=1.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdy,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdy,
        output imem_data
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one request at a time, delivers words to the IF/ID
// register, absorbs one word in a hold buffer during stalls, and redirects on branches.
// REDIR drains a stale in-flight request before fetching from the pending target.
module fetch_unit (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         br_taken,
    input  logic [15:0]  br_target,
    fetch_unit_if.master imem,
    output logic [31:0]  ID_inst,
    output logic [31:0]  ID_pc,
    output logic         ID_valid
);

    typedef enum logic [0:0] {StRun, StRedir} state_e;

    state_e      r_state, w_state_d;
    logic [31:0] r_pc, w_pc_d;
    logic [31:0] r_hold_inst, w_hold_inst_d;
    logic [31:0] r_hold_pc, w_hold_pc_d;
    logic        r_hold_valid, w_hold_valid_d;
    logic [31:0] r_pending, w_pending_d;
    logic [31:0] r_id_inst, w_id_inst_d;
    logic [31:0] r_id_pc, w_id_pc_d;
    logic        r_id_valid, w_id_valid_d;

    logic        w_req;
    logic        w_accept;
    logic        w_branch;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    // A full hold buffer blocks new requests; the address is always the current pc,
    // which stays at the stale value throughout REDIR.
    assign w_req          = reset & ~r_hold_valid;
    assign w_accept       = w_req & imem.imem_rdy;
    assign w_branch       = br_taken & ~stall;
    assign w_target       = {16'h0000, br_target};
    assign w_pc_inc       = r_pc + 32'd4;
    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;
    assign ID_inst        = r_id_inst;
    assign ID_pc          = r_id_pc;
    assign ID_valid       = r_id_valid;

    // Next-state logic: branch (when not stalled) beats stall, stall beats normal flow.
    always_comb begin
        w_state_d      = r_state;
        w_pc_d         = r_pc;
        w_hold_inst_d  = r_hold_inst;
        w_hold_pc_d    = r_hold_pc;
        w_hold_valid_d = r_hold_valid;
        w_pending_d    = r_pending;
        w_id_inst_d    = r_id_inst;
        w_id_pc_d      = r_id_pc;
        w_id_valid_d   = r_id_valid;

        unique case (r_state)
            StRun: begin
                if (w_branch) begin
                    w_id_valid_d   = 1'b0;
                    w_hold_valid_d = 1'b0;
                    if (w_accept || !w_req) begin
                        w_pc_d = w_target;
                    end else begin
                        // Request still in flight: its response must be dropped first.
                        w_pending_d = w_target;
                        w_state_d   = StRedir;
                    end
                end else if (stall) begin
                    if (w_accept) begin
                        w_hold_inst_d  = imem.imem_data;
                        w_hold_pc_d    = r_pc;
                        w_hold_valid_d = 1'b1;
                        w_pc_d         = w_pc_inc;
                    end
                end else if (r_hold_valid) begin
                    w_id_inst_d    = r_hold_inst;
                    w_id_pc_d      = r_hold_pc;
                    w_id_valid_d   = 1'b1;
                    w_hold_valid_d = 1'b0;
                end else if (w_accept) begin
                    w_id_inst_d  = imem.imem_data;
                    w_id_pc_d    = r_pc;
                    w_id_valid_d = 1'b1;
                    w_pc_d       = w_pc_inc;
                end else begin
                    w_id_valid_d = 1'b0;
                end
            end
            StRedir: begin
                if (!stall) begin
                    w_id_valid_d = 1'b0;
                end
                if (w_branch) begin
                    w_pending_d = w_target;
                end
                if (w_accept) begin
                    // Stale response is discarded; the latest target wins.
                    w_pc_d    = w_branch ? w_target : r_pending;
                    w_state_d = StRun;
                end
            end
            default: w_state_d = StRun;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= StRun;
            r_pc         <= 32'h0;
            r_hold_inst  <= 32'h0;
            r_hold_pc    <= 32'h0;
            r_hold_valid <= 1'b0;
            r_pending    <= 32'h0;
            r_id_inst    <= 32'h0;
            r_id_pc      <= 32'h0;
            r_id_valid   <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_pc         <= w_pc_d;
            r_hold_inst  <= w_hold_inst_d;
            r_hold_pc    <= w_hold_pc_d;
            r_hold_valid <= w_hold_valid_d;
            r_pending    <= w_pending_d;
            r_id_inst    <= w_id_inst_d;
            r_id_pc      <= w_id_pc_d;
            r_id_valid   <= w_id_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// compared against a queue-based behavioural model.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_target;
    logic        rdy;
    logic        use_rand;
    logic [31:0] rand_data;
    logic [31:0] ID_inst;
    logic [31:0] ID_pc;
    logic        ID_valid;

    int n_checks;
    int n_errors;

    fetch_unit_if bus ();

    assign bus.imem_rdy  = rdy;
    assign bus.imem_data = use_rand ? rand_data : (32'h1000 + bus.imem_addr);

    fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .imem      (bus),
        .ID_inst   (ID_inst),
        .ID_pc     (ID_pc),
        .ID_valid  (ID_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 16'h0;
        rdy = 1'b1; use_rand = 1'b0; rand_data = 32'h0;
        #1;
        n_checks++;
        if (bus.imem_req !== 1'b0) begin
            n_errors++; $display("FAIL reset_req_early: got %b want 0", bus.imem_req);
        end
        tick(); tick();
        n_checks++;
        if (ID_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_valid: got %b want 0", ID_valid);
        end
        n_checks++;
        if (ID_inst !== 32'h0) begin
            n_errors++; $display("FAIL reset_inst: got %h want 0", ID_inst);
        end
        n_checks++;
        if (ID_pc !== 32'h0) begin
            n_errors++; $display("FAIL reset_pc: got %h want 0", ID_pc);
        end
        n_checks++;
        if (bus.imem_req !== 1'b0) begin
            n_errors++; $display("FAIL reset_req: got %b want 0", bus.imem_req);
        end
    endtask

    task automatic test_straight_line();
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0",
                     bus.imem_req, bus.imem_addr);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (ID_valid !== 1'b1 || ID_pc !== 32'(4 * i) || ID_inst !== 32'(32'h1000 + 4 * i))
            begin
                n_errors++;
                $display("FAIL straight_%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         i, ID_valid, ID_pc, ID_inst, 32'(4 * i), 32'(32'h1000 + 4 * i));
            end
            n_checks++;
            if (bus.imem_addr !== 32'(4 * (i + 1))) begin
                n_errors++;
                $display("FAIL straight_addr_%0d: got %h want %h", i, bus.imem_addr,
                         32'(4 * (i + 1)));
            end
        end
    endtask

    task automatic test_stall_buffer();
        // Word at 24 is accepted on the first stalled cycle and held.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (ID_valid !== 1'b1 || ID_pc !== 32'd20 || ID_inst !== 32'h1014) begin
                n_errors++;
                $display("FAIL stall_frozen_%0d: got v=%b pc=%h inst=%h want v=1 pc=14 inst=1014",
                         i, ID_valid, ID_pc, ID_inst);
            end
            n_checks++;
            if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'd28) begin
                n_errors++;
                $display("FAIL stall_req_%0d: got req=%b addr=%h want req=0 addr=1c",
                         i, bus.imem_req, bus.imem_addr);
            end
        end
        stall = 1'b0;
        tick();
        n_checks++;
        if (ID_valid !== 1'b1 || ID_pc !== 32'd24 || ID_inst !== 32'h1018) begin
            n_errors++;
            $display("FAIL stall_held_word: got v=%b pc=%h inst=%h want v=1 pc=18 inst=1018",
                     ID_valid, ID_pc, ID_inst);
        end
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd28) begin
            n_errors++;
            $display("FAIL stall_resume_req: got req=%b addr=%h want req=1 addr=1c",
                     bus.imem_req, bus.imem_addr);
        end
        tick();
        n_checks++;
        if (ID_valid !== 1'b1 || ID_pc !== 32'd28 || ID_inst !== 32'h101c) begin
            n_errors++;
            $display("FAIL stall_resume: got v=%b pc=%h inst=%h want v=1 pc=1c inst=101c",
                     ID_valid, ID_pc, ID_inst);
        end
    endtask

    task automatic test_branch_immediate();
        br_taken = 1'b1; br_target = 16'h0040;
        tick();
        br_taken = 1'b0;
        n_checks++;
        if (ID_valid !== 1'b0 || bus.imem_addr !== 32'h40 || bus.imem_req !== 1'b1) begin
            n_errors++;
            $display("FAIL br_imm_redirect: got v=%b addr=%h req=%b want v=0 addr=40 req=1",
                     ID_valid, bus.imem_addr, bus.imem_req);
        end
        tick();
        n_checks++;
        if (ID_valid !== 1'b1 || ID_pc !== 32'h40 || ID_inst !== 32'h1040) begin
            n_errors++;
            $display("FAIL br_imm_target: got v=%b pc=%h inst=%h want v=1 pc=40 inst=1040",
                     ID_valid, ID_pc, ID_inst);
        end
    endtask

    task automatic test_branch_slow();
        rdy = 1'b0; br_taken = 1'b1; br_target = 16'h0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            br_taken = 1'b0;
            n_checks++;
            if (ID_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h44) begin
                n_errors++;
                $display("FAIL br_slow_wait_%0d: got v=%b req=%b addr=%h want v=0 req=1 addr=44",
                         i, ID_valid, bus.imem_req, bus.imem_addr);
            end
        end
        rdy = 1'b1;
        tick();
        n_checks++;
        if (ID_valid !== 1'b0 || bus.imem_addr !== 32'h100) begin
            n_errors++;
            $display("FAIL br_slow_drop: got v=%b addr=%h want v=0 addr=100",
                     ID_valid, bus.imem_addr);
        end
        tick();
        n_checks++;
        if (ID_valid !== 1'b1 || ID_pc !== 32'h100 || ID_inst !== 32'h1100) begin
            n_errors++;
            $display("FAIL br_slow_target: got v=%b pc=%h inst=%h want v=1 pc=100 inst=1100",
                     ID_valid, ID_pc, ID_inst);
        end
    endtask

    task automatic test_wrap();
        // The top of the address space is unreachable through 16-bit targets, so preload pc.
        rdy = 1'b0;
        force dut.r_pc = 32'hFFFF_FFFC;
        tick();
        release dut.r_pc;
        #1;
        n_checks++;
        if (bus.imem_addr !== 32'hFFFF_FFFC) begin
            n_errors++; $display("FAIL wrap_preload: got %h want fffffffc", bus.imem_addr);
        end
        rdy = 1'b1;
        tick();
        n_checks++;
        if (ID_valid !== 1'b1 || ID_pc !== 32'hFFFF_FFFC || ID_inst !== 32'h0000_0FFC) begin
            n_errors++;
            $display("FAIL wrap_id: got v=%b pc=%h inst=%h want v=1 pc=fffffffc inst=ffc",
                     ID_valid, ID_pc, ID_inst);
        end
        n_checks++;
        if (bus.imem_addr !== 32'h0) begin
            n_errors++; $display("FAIL wrap_pc: got %h want 0", bus.imem_addr);
        end
    endtask

    task automatic test_reset_mid_request();
        rdy = 1'b1;
        tick();
        rdy = 1'b0; br_taken = 1'b1; br_target = 16'h0200;
        tick();
        br_taken = 1'b0; reset = 1'b0; rdy = 1'b1;
        #1;
        n_checks++;
        if (bus.imem_req !== 1'b0) begin
            n_errors++; $display("FAIL midreset_req: got %b want 0", bus.imem_req);
        end
        tick();
        n_checks++;
        if (ID_valid !== 1'b0 || ID_inst !== 32'h0 || ID_pc !== 32'h0 ||
            bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL midreset_outputs: got v=%b inst=%h pc=%h req=%b addr=%h want all 0",
                     ID_valid, ID_inst, ID_pc, bus.imem_req, bus.imem_addr);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (ID_valid !== 1'b1 || ID_pc !== 32'h0 || ID_inst !== 32'h1000) begin
            n_errors++;
            $display("FAIL midreset_first: got v=%b pc=%h inst=%h want v=1 pc=0 inst=1000",
                     ID_valid, ID_pc, ID_inst);
        end
    endtask

    // Reference model: a fetch pointer, a queue of words parked during stalls, and a flag
    // saying the in-flight response belongs to a superseded path.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    task automatic test_random();
        ent_t        m_held[$];
        logic [31:0] m_fetch;
        logic        m_stale;
        logic [31:0] m_redirect;
        logic [31:0] m_id_inst;
        logic [31:0] m_id_pc;
        logic        m_id_valid;
        logic        m_req;
        logic        m_acc;
        bit          go;

        use_rand = 1'b1; reset = 1'b0; stall = 1'b0; br_taken = 1'b0;
        tick();
        m_held.delete(); m_fetch = 0; m_stale = 0; m_redirect = 0;
        m_id_inst = 0; m_id_pc = 0; m_id_valid = 0;
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 99) != 0);
            stall     = ($urandom_range(0, 3) == 0);
            br_taken  = ($urandom_range(0, 7) == 0);
            br_target = 16'($urandom);
            rdy       = ($urandom_range(0, 2) != 0);
            rand_data = $urandom;
            #1;
            m_req = reset && (m_held.size() == 0);
            m_acc = m_req && rdy;
            n_checks++;
            if (bus.imem_req !== m_req || bus.imem_addr !== m_fetch) begin
                n_errors++;
                $display("FAIL rand_req_c%0d: got req=%b addr=%h want req=%b addr=%h",
                         c, bus.imem_req, bus.imem_addr, m_req, m_fetch);
            end
            go = 1'b1;
            if (!reset) begin
                m_held.delete(); m_fetch = 0; m_stale = 0; m_redirect = 0;
                m_id_inst = 0; m_id_pc = 0; m_id_valid = 0;
                go = 1'b0;
            end else if (m_stale) begin
                if (br_taken && !stall) m_redirect = {16'h0, br_target};
                if (m_acc) begin
                    m_fetch = m_redirect;
                    m_stale = 0;
                end
                if (!stall) m_id_valid = 0;
                go = 1'b0;
            end else if (br_taken && !stall) begin
                m_held.delete();
                m_id_valid = 0;
                if (m_req && !rdy) begin
                    m_stale    = 1;
                    m_redirect = {16'h0, br_target};
                end else begin
                    m_fetch = {16'h0, br_target};
                end
                go = 1'b0;
            end
            if (go) begin
                if (stall) begin
                    if (m_acc) begin
                        m_held.push_back('{inst: rand_data, pc: m_fetch});
                        m_fetch = m_fetch + 4;
                    end
                end else if (m_held.size() != 0) begin
                    m_id_inst  = m_held[0].inst;
                    m_id_pc    = m_held[0].pc;
                    m_id_valid = 1;
                    void'(m_held.pop_front());
                end else if (m_acc) begin
                    m_id_inst  = rand_data;
                    m_id_pc    = m_fetch;
                    m_id_valid = 1;
                    m_fetch    = m_fetch + 4;
                end else begin
                    m_id_valid = 0;
                end
            end
            tick();
            n_checks++;
            if (ID_valid !== m_id_valid || ID_inst !== m_id_inst || ID_pc !== m_id_pc) begin
                n_errors++;
                $display("FAIL rand_id_c%0d: got v=%b pc=%h inst=%h want v=%b pc=%h inst=%h",
                         c, ID_valid, ID_pc, ID_inst, m_id_valid, m_id_pc, m_id_inst);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_straight_line();
        test_stall_buffer();
        test_branch_immediate();
        test_branch_slow();
        test_wrap();
        test_reset_mid_request();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
